// File: rtl/ddr2_aref_ctrl.sv
// DDR2 periodic auto-refresh controller: tREFI timer, refresh debt, PRE-ALL/AREF sequencer.
// Define AREF_POSTPONE_EN to allow postponing up to MAX_DEBT refreshes and draining them in one grant.
module ddr2_aref_ctrl #(
   parameter int ADDR_BITS = 14,
   parameter int BA_BITS   = 3,
   parameter int TREFI_CK  = 3120,
   parameter int TRP_CK    = 5,
   parameter int TRFC_CK   = 51,
   parameter int MAX_DEBT  = 8
) (
   input  logic                 ck,
   input  logic                 rst,
   input  logic                 init_end,
   input  logic                 aref_ack,
   output logic                 aref_req,
   output logic                 aref_urgent,
   output logic [3:0]           aref_cmd,
   output logic [ADDR_BITS-1:0] aref_addr,
   output logic [BA_BITS-1:0]   aref_ba,
   output logic                 aref_end
);

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;

`ifdef AREF_POSTPONE_EN
   localparam int LIMIT = MAX_DEBT;
`else
   localparam int LIMIT = 1;
`endif
   localparam int DW   = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
   localparam int TW   = $clog2(TREFI_CK);
   localparam int CMAX = (TRP_CK > TRFC_CK) ? TRP_CK : TRFC_CK;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [DW-1:0] LIM_V = DW'(LIMIT);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [DW-1:0]          debt_q, debt_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   req_q, req_d;
   logic                   urg_q, urg_d;
   logic [3:0]             cmd_q, cmd_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic                   end_q, end_d;
   logic                   wrap, dec;
   logic                   more_wait, more_ref;

   // Interval timer and refresh debt
   always_comb begin
      wrap    = init_end && (timer_q == TW'(TREFI_CK - 1));
      timer_d = (!init_end || wrap) ? '0 : timer_q + TW'(1);
      dec     = (state_q == S_REF) && (debt_q != '0);
      debt_d  = debt_q;
      if (!init_end)
         debt_d = '0;
      else if (wrap && dec)
         debt_d = debt_q;
      else if (wrap && (debt_q != LIM_V))
         debt_d = debt_q + DW'(1);
      else if (dec)
         debt_d = debt_q - DW'(1);
   end

   // Only the postponing build chains refreshes inside one grant.
`ifdef AREF_POSTPONE_EN
   assign more_wait = (debt_q != '0);
   assign more_ref  = (debt_d != '0);
`else
   assign more_wait = 1'b0;
   assign more_ref  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (debt_q != '0) state_d = S_REQ;
         S_REQ:  if (aref_ack) state_d = S_PRE;
         S_PRE: begin
            if (TRP_CK == 1) state_d = S_REF;
            else begin
               state_d = S_WAIT_RP;
               cnt_d   = CW'(TRP_CK - 2);
            end
         end
         S_WAIT_RP: begin
            if (cnt_q == '0) state_d = S_REF;
            else cnt_d = cnt_q - CW'(1);
         end
         S_REF: begin
            if (TRFC_CK == 1) state_d = more_ref ? S_REF : S_DONE;
            else begin
               state_d = S_WAIT_RFC;
               cnt_d   = CW'(TRFC_CK - 2);
            end
         end
         S_WAIT_RFC: begin
            if (cnt_q == '0) state_d = more_wait ? S_REF : S_DONE;
            else cnt_d = cnt_q - CW'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      req_d  = (state_d == S_REQ);
      end_d  = (state_d == S_DONE);
      urg_d  = (debt_d == LIM_V);
      cmd_d  = CMD_NOP;
      addr_d = '0;
      if (state_d == S_PRE) begin
         cmd_d      = CMD_PRE;
         addr_d[10] = 1'b1;
      end else if (state_d == S_REF) begin
         cmd_d = CMD_AREF;
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         debt_q  <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         urg_q   <= 1'b0;
         cmd_q   <= CMD_NOP;
         addr_q  <= '0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         debt_q  <= debt_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         urg_q   <= urg_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         end_q   <= end_d;
      end
   end

   assign aref_req    = req_q;
   assign aref_urgent = urg_q;
   assign aref_cmd    = cmd_q;
   assign aref_addr   = addr_q;
   assign aref_ba     = '0;
   assign aref_end    = end_q;

endmodule

// File: tb/tb_ddr2_aref_ctrl.sv
// Scoreboard bench for ddr2_aref_ctrl: an event-schedule model predicts request, PRE, AREF and end times.
module tb_ddr2_aref_ctrl;
   localparam int ADDR_BITS = 14;
   localparam int BA_BITS   = 3;
   localparam int TREFI_CK  = 100;
   localparam int TRP_CK    = 5;
   localparam int TRFC_CK   = 51;
   localparam int MAX_DEBT  = 8;
`ifdef AREF_POSTPONE_EN
   localparam int LIM      = MAX_DEBT;
   localparam int WITHHOLD = 950;
`else
   localparam int LIM      = 1;
   localparam int WITHHOLD = 350;
`endif
   localparam int BIG = 32'h7fff_ffff;

   logic ck = 1'b0, rst = 1'b1, init_end = 1'b0, aref_ack = 1'b0;
   logic aref_req, aref_urgent, aref_end;
   logic [3:0] aref_cmd;
   logic [ADDR_BITS-1:0] aref_addr;
   logic [BA_BITS-1:0] aref_ba;

   ddr2_aref_ctrl #(.ADDR_BITS(ADDR_BITS), .BA_BITS(BA_BITS), .TREFI_CK(TREFI_CK),
                    .TRP_CK(TRP_CK), .TRFC_CK(TRFC_CK), .MAX_DEBT(MAX_DEBT)) dut (
      .ck(ck), .rst(rst), .init_end(init_end), .aref_ack(aref_ack),
      .aref_req(aref_req), .aref_urgent(aref_urgent), .aref_cmd(aref_cmd),
      .aref_addr(aref_addr), .aref_ba(aref_ba), .aref_end(aref_end));

   always #5 ck = ~ck;

   // kind: 0 request rises, 1 PRE, 2 AREF, 3 end pulse
   typedef struct { int kind; int cyc; } ev_t;
   ev_t evq[$];
   bit  decq[int];
   int  cyc = 0, mdebt = 0, tcount = 0, idle_from = 0;
   int  n_chk = 0, n_fail = 0;

   // Reference model: edge-indexed debt bookkeeping and request prediction
   always @(posedge ck) begin
      bit w, d;
      cyc = cyc + 1;
      if (rst) begin
         mdebt = 0; tcount = 0; evq.delete(); decq.delete(); idle_from = cyc;
      end else begin
         if (cyc > idle_from && mdebt > 0) begin
            evq.push_back('{0, cyc});
            idle_from = BIG;
         end
         w = 1'b0;
         if (!init_end) tcount = 0;
         else begin
            tcount = tcount + 1;
            w = (tcount % TREFI_CK) == 0;
         end
         d = decq.exists(cyc) && mdebt > 0;
         if (!init_end) mdebt = 0;
         else if (w && d) mdebt = mdebt;
         else if (w && mdebt < LIM) mdebt = mdebt + 1;
         else if (d) mdebt = mdebt - 1;
      end
   end

   // Monitor: per-cycle output checks and scoreboard pops
   logic prev_req = 1'b0;
   int   kind;
   ev_t  e;
   logic [ADDR_BITS-1:0] exp_addr;
   always @(negedge ck) begin
      if (cyc > 0) begin
         n_chk++;
         if (aref_urgent !== (mdebt == LIM)) begin
            n_fail++;
            $display("FAIL urgent cyc=%0d got=%b want=%b", cyc, aref_urgent, mdebt == LIM);
         end
         exp_addr = '0;
         if (aref_cmd == 4'b0010) exp_addr[10] = 1'b1;
         n_chk++;
         if (aref_addr !== exp_addr || aref_ba !== '0) begin
            n_fail++;
            $display("FAIL addr_ba cyc=%0d got=%h/%h want=%h/0", cyc, aref_addr, aref_ba, exp_addr);
         end
         kind = -1;
         if (aref_cmd == 4'b0010) kind = 1;
         else if (aref_cmd == 4'b0001) kind = 2;
         else if (aref_cmd != 4'b0111) begin
            n_chk++; n_fail++;
            $display("FAIL cmd_code cyc=%0d got=%b", cyc, aref_cmd);
         end
         if (aref_end === 1'b1) kind = 3;
         if (aref_req === 1'b1 && prev_req !== 1'b1) kind = 0;
         prev_req = aref_req;
         while (evq.size() > 0 && evq[0].cyc < cyc) begin
            e = evq.pop_front();
            n_chk++; n_fail++;
            $display("FAIL missing_event kind=%0d got=none want_cyc=%0d now=%0d", e.kind, e.cyc, cyc);
         end
         if (kind >= 0) begin
            n_chk++;
            if (evq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event kind=%0d cyc=%0d want=none", kind, cyc);
            end else begin
               e = evq.pop_front();
               if (e.kind != kind || e.cyc != cyc) begin
                  n_fail++;
                  $display("FAIL event got kind=%0d cyc=%0d want kind=%0d cyc=%0d", kind, cyc, e.kind, e.cyc);
               end
            end
         end
      end
   end

   // Schedule a whole grant from the current debt and the arithmetic wrap times.
   task automatic plan_burst();
      int m = cyc, r, k;
`ifdef AREF_POSTPONE_EN
      int d = mdebt, tc = tcount;
      bit w, dd;
`endif
      evq.push_back('{1, m + 1});
      r = m + 1 + TRP_CK;
      k = m + 1;
      while (1) begin
         evq.push_back('{2, r});
         decq[r + 1] = 1'b1;
`ifdef AREF_POSTPONE_EN
         for (; k <= r + TRFC_CK - 1; k++) begin
            w  = ((tc + k - m) % TREFI_CK) == 0;
            dd = (k == r + 1) && d > 0;
            if (w && dd) d = d;
            else if (w && d < LIM) d = d + 1;
            else if (dd) d = d - 1;
         end
         if (d > 0) r = r + TRFC_CK;
         else break;
`else
         break;
`endif
      end
      evq.push_back('{3, r + TRFC_CK});
      idle_from = r + TRFC_CK + 1;
   endtask

   task automatic chk_reset_outs(input string tag);
      n_chk++;
      if (aref_cmd !== 4'b0111 || aref_req !== 1'b0 || aref_urgent !== 1'b0 ||
          aref_end !== 1'b0 || aref_addr !== '0 || aref_ba !== '0) begin
         n_fail++;
         $display("FAIL %s got cmd=%b req=%b urg=%b end=%b addr=%h want cmd=0111 rest=0",
                  tag, aref_cmd, aref_req, aref_urgent, aref_end, aref_addr);
      end
   endtask

   initial begin
      bit ok;
      repeat (3) @(negedge ck);
      chk_reset_outs("reset_state");
      rst = 1'b0;
      repeat (500) @(negedge ck);
      chk_reset_outs("idle_no_init");
      init_end = 1'b1;
      for (int i = 0; i < 12; i++) begin
         ok = 1'b0;
         for (int k = 0; k < 1500; k++) begin
            @(negedge ck);
            aref_ack = 1'b0;
            if (aref_req === 1'b1) begin ok = 1'b1; break; end
            if ($urandom_range(0, 7) == 0) aref_ack = 1'b1;
         end
         if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL req_timeout grant=%0d got=no_req want=req", i);
            break;
         end
         if (i == 2) repeat (WITHHOLD) @(negedge ck);
         else if (i == 4) begin
            for (int k = 0; k < TREFI_CK + 2; k++) begin
               if ((tcount % TREFI_CK) == TREFI_CK - TRP_CK - 2) break;
               @(negedge ck);
            end
         end else repeat ($urandom_range(0, 4)) @(negedge ck);
         plan_burst();
         aref_ack = 1'b1;
         @(negedge ck);
         aref_ack = 1'b0;
         if (i == 6) begin
            repeat (20) @(negedge ck);
            rst = 1'b1;
            @(negedge ck);
            chk_reset_outs("reset_mid_rfc");
            rst = 1'b0;
         end else begin
            ok = 1'b0;
            for (int k = 0; k < 2000; k++) begin
               @(negedge ck);
               if (aref_end === 1'b1) begin ok = 1'b1; break; end
            end
            if (!ok) begin
               n_chk++; n_fail++;
               $display("FAIL end_timeout grant=%0d got=no_end want=end", i);
            end
         end
      end
      repeat (60) @(negedge ck);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
